trace_buffer: RTL and testbench

Retire-trace capture buffer on the Main CPU's observation outputs (inst, addr, aluout, memout).
- Records one 128-bit entry per retired instruction into a FIFO.
- Optional PC trigger starts capture; an arm/stop control FSM bounds it.
- Consumer drains entries over a valid/ready port.

---
 rtl/trace_buffer.sv | 143 ++++++++++++++
 tb/tb_trace_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_buffer.sv
// Retire-trace capture FIFO with arm/trigger/stop control and FWFT drain port.
// Optional macro TRACE_FILTER_EN: only lw/sw records are capture attempts.
module trace_buffer #(
    parameter int DEPTH     = 16,
    parameter int CAP_LIMIT = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          Clk,
    input  logic          Clrn,
    input  logic          valid_in,
    input  logic [31:0]   inst,
    input  logic [31:0]   addr,
    input  logic [31:0]   aluout,
    input  logic [31:0]   memout,
    input  logic          arm,
    input  logic          stop,
    input  logic          clear,
    input  logic          trig_en,
    input  logic [31:0]   trig_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic [AW:0]   count,
    output logic [15:0]   drop_cnt,
    output logic [1:0]    state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [31:0] LIM  = 32'(CAP_LIMIT);

    state_t        state_q, state_d;
    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q;
    logic [15:0]   drop_q;
    logic [31:0]   cap_q;
    logic [127:0]  hold_q;

    logic pass, hit, attempt, cap_zero;
    logic do_pop, do_write, limit_hit;

`ifdef TRACE_FILTER_EN
    assign pass = (inst[31:26] == 6'h23) || (inst[31:26] == 6'h2b);
`else
    assign pass = 1'b1;
`endif

    assign hit       = valid_in && (addr == trig_addr);
    assign out_valid = (count_q != '0);
    assign do_pop    = out_valid && out_ready && !clear;
    // A full FIFO still accepts a record when the head leaves on the same edge.
    assign do_write  = attempt && !clear && ((count_q != FULL) || do_pop);
    assign limit_hit = (LIM != 32'd0) && do_write && (cap_q + 32'd1 == LIM);

    always_comb begin
        state_d  = state_q;
        attempt  = 1'b0;
        cap_zero = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arm && !stop) begin
                    state_d  = ARMED;
                    cap_zero = 1'b1;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!trig_en) begin
                    state_d = CAPTURE;
                end else if (hit) begin
                    state_d = CAPTURE;
                    attempt = pass;
                end
            end
            CAPTURE: begin
                if (stop) state_d = DONE;
                else      attempt = valid_in && pass;
            end
            DONE: begin
                if (arm && !stop) begin
                    state_d  = ARMED;
                    cap_zero = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (limit_hit) state_d = DONE;
    end

    always_ff @(posedge Clk) begin
        if (!Clrn && do_write) mem[wr_ptr] <= {addr, inst, aluout, memout};
    end

    always_ff @(posedge Clk) begin
        if (Clrn) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            cap_q   <= '0;
            hold_q  <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            if (do_write) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                hold_q <= mem[rd_ptr];
            end
            unique case ({do_write, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (attempt && !do_write && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;
            if (cap_zero)      cap_q <= '0;
            else if (do_write) cap_q <= cap_q + 32'd1;
        end
    end

    // Empty FIFO keeps presenting the last entry that left.
    assign out_data = out_valid ? mem[rd_ptr] : hold_q;
    assign count    = count_q;
    assign drop_cnt = drop_q;
    assign state    = state_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Randomized + directed bench for trace_buffer against a queue-level model.
// Two instances share stimulus: DEPTH=16 unlimited, and DEPTH=4 with CAP_LIMIT=3.
module tb_trace_buffer;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Clrn, valid_in, arm, stop, clear, trig_en, out_ready;
    logic [31:0] inst, addr, aluout, memout, trig_addr;

    logic         ov0, ov1;
    logic [127:0] od0, od1;
    logic [4:0]   cnt0;
    logic [2:0]   cnt1;
    logic [15:0]  drop0, drop1;
    logic [1:0]   st0, st1;

    trace_buffer #(.DEPTH(16), .CAP_LIMIT(0)) dut0 (
        .Clk(Clk), .Clrn(Clrn), .valid_in(valid_in), .inst(inst),
        .addr(addr), .aluout(aluout), .memout(memout), .arm(arm),
        .stop(stop), .clear(clear), .trig_en(trig_en),
        .trig_addr(trig_addr), .out_valid(ov0), .out_ready(out_ready),
        .out_data(od0), .count(cnt0), .drop_cnt(drop0), .state(st0)
    );

    trace_buffer #(.DEPTH(4), .CAP_LIMIT(3)) dut1 (
        .Clk(Clk), .Clrn(Clrn), .valid_in(valid_in), .inst(inst),
        .addr(addr), .aluout(aluout), .memout(memout), .arm(arm),
        .stop(stop), .clear(clear), .trig_en(trig_en),
        .trig_addr(trig_addr), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .count(cnt1), .drop_cnt(drop1), .state(st1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: circular store with an element count, per instance.
    int           mst[2], mn[2], mhead[2], mdrop[2], mcap[2];
    logic [127:0] mhold[2];
    logic [127:0] mbuf[2][16];

    function automatic bit passes(input logic [31:0] w);
`ifdef TRACE_FILTER_EN
        return (w[31:26] == 6'h23) || (w[31:26] == 6'h2b);
`else
        return (w != 32'hFFFF_FFFF) || 1'b1;
`endif
    endfunction

    task automatic model_step(input int k);
        int d, lim, idx;
        bit pop, att, wr;
        d   = (k == 0) ? 16 : 4;
        lim = (k == 0) ? 0 : 3;
        if (Clrn) begin
            mst[k] = 0; mn[k] = 0; mhead[k] = 0;
            mdrop[k] = 0; mcap[k] = 0; mhold[k] = '0;
            return;
        end
        if (clear) begin
            mst[k] = 0; mn[k] = 0; mhead[k] = 0;
            mdrop[k] = 0; mcap[k] = 0;
            return;
        end
        pop = (mn[k] > 0) && out_ready;
        att = 0;
        case (mst[k])
            0: if (arm && !stop) begin mst[k] = 1; mcap[k] = 0; end
            1: begin
                if (stop) mst[k] = 0;
                else if (!trig_en) mst[k] = 2;
                else if (valid_in && addr == trig_addr) begin
                    mst[k] = 2;
                    att = passes(inst);
                end
            end
            2: if (stop) mst[k] = 3; else att = valid_in && passes(inst);
            default: if (arm && !stop) begin mst[k] = 1; mcap[k] = 0; end
        endcase
        wr = att && (mn[k] < d || pop);
        if (att && !wr && mdrop[k] < 65535) mdrop[k]++;
        idx = (mhead[k] + mn[k]) % d;
        if (pop) begin
            mhold[k] = mbuf[k][mhead[k]];
            mhead[k] = (mhead[k] + 1) % d;
            mn[k]--;
        end
        if (wr) begin
            mbuf[k][idx] = {addr, inst, aluout, memout};
            mn[k]++;
            mcap[k]++;
            if (lim != 0 && mcap[k] == lim) mst[k] = 3;
        end
    endtask

    function automatic logic [127:0] exp_data(input int k);
        return (mn[k] > 0) ? mbuf[k][mhead[k]] : mhold[k];
    endfunction

    task automatic compare_all();
        check("st0",   st0,   128'(mst[0]));
        check("cnt0",  cnt0,  128'(mn[0]));
        check("drop0", drop0, 128'(mdrop[0]));
        check("ov0",   ov0,   128'(mn[0] > 0));
        check("od0",   od0,   exp_data(0));
        check("st1",   st1,   128'(mst[1]));
        check("cnt1",  cnt1,  128'(mn[1]));
        check("drop1", drop1, 128'(mdrop[1]));
        check("ov1",   ov1,   128'(mn[1] > 0));
        check("od1",   od1,   exp_data(1));
    endtask

    task automatic step();
        @(posedge Clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    task automatic retire(input logic [31:0] a, input logic [5:0] op);
        valid_in = 1'b1;
        addr     = a;
        inst     = {op, 26'($urandom)};
        aluout   = $urandom;
        memout   = $urandom;
        step();
        valid_in = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    logic [5:0] ops [4];

    initial begin
        ops = '{6'h00, 6'h23, 6'h08, 6'h2b};
        Clrn = 1'b1; valid_in = 1'b1; arm = 1'b1; stop = 1'b1;
        clear = 1'b1; trig_en = 1'b1; out_ready = 1'b1;
        inst = $urandom; addr = $urandom; aluout = $urandom;
        memout = $urandom; trig_addr = addr;
        step();
        step();
        check("rst_state", st0, 0);
        check("rst_count", cnt0, 0);
        check("rst_valid", ov0, 0);
        check("rst_drop", drop0, 0);
        check("rst_data", od0, 0);

        Clrn = 1'b0; valid_in = 1'b0; arm = 1'b0; stop = 1'b0;
        clear = 1'b0; trig_en = 1'b0; out_ready = 1'b0;
        do_arm();
        step();
        for (int i = 0; i < 5; i++) retire(32'(4 * i), 6'h23);
        check("imm_count", cnt0, 5);
        check("imm_state", st0, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("imm_order", od0[127:96], 128'(4 * i));
            step();
        end
        check("imm_drained", cnt0, 0);
        check("imm_nvalid", ov0, 0);
        out_ready = 1'b0;
        do_clear();

        trig_en = 1'b1;
        trig_addr = 32'h40;
        do_arm();
        for (int i = 0; i < 8; i++) retire(32'h30 + 32'(4 * i), 6'h2b);
        check("trig_count", cnt0, 4);
        check("trig_head", od0[127:96], 32'h40);
        do_clear();

        trig_en = 1'b0;
        do_arm();
        step();
        for (int i = 0; i < 20; i++) retire(32'(4 * i), 6'h23);
        check("full_count", cnt0, 16);
        check("full_drop", drop0, 4);
        out_ready = 1'b1;
        retire(32'h100, 6'h23);
        check("full_pp_count", cnt0, 16);
        check("full_pp_drop", drop0, 4);
        out_ready = 1'b0;
        do_clear();

        do_arm();
        step();
        for (int i = 0; i < 6; i++) begin
            retire(32'(4 * i), 6'h2b);
            if (i == 2) check("lim_done_at3", st1, 3);
        end
        check("lim_count", cnt1, 3);
        check("lim_drop", drop1, 0);
        do_clear();
        check("lim_clr_state", st1, 0);
        check("lim_clr_count", cnt1, 0);

        do_arm();
        step();
        for (int i = 0; i < 4; i++) retire(32'(4 * i), ops[i]);
`ifdef TRACE_FILTER_EN
        check("flt_count", cnt0, 2);
        check("flt_first", od0[95:90], 6'h23);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("flt_second", od0[95:90], 6'h2b);
`else
        check("flt_count", cnt0, 4);
`endif
        do_clear();

        for (int n = 0; n < 3000; n++) begin
            Clrn      = ($urandom % 100) == 0;
            clear     = ($urandom % 40) == 0;
            stop      = ($urandom % 20) == 0;
            arm       = ($urandom % 8) == 0;
            valid_in  = ($urandom % 3) != 0;
            out_ready = ($urandom % 3) == 0;
            trig_en   = $urandom % 2;
            trig_addr = 32'h40 + 32'(4 * ($urandom % 2));
            addr      = 32'h40 + 32'(4 * ($urandom % 4));
            inst      = {ops[$urandom % 4], 26'($urandom)};
            aluout    = $urandom;
            memout    = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
